// File: rtl/mod3_frame_sched.sv
// Round-robin front end that time-shares one serial divisible-by-3 detector between two word requesters.
// Optional remainder cross-check built when MOD3_SCHED_SELFCHECK_EN is defined.
module mod3_frame_sched #(
  parameter int unsigned W       = 24,
  parameter int unsigned DET_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         det_clr_n,
  output logic         det_din,
  input  logic         det_dout,
  output logic         resp_valid,
  output logic         resp_id,
  output logic         resp_div3,
  output logic         resp_mismatch,
  output logic         busy
);

  localparam int unsigned CMAX = (W > DET_LAT) ? W : DET_LAT;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           id_q, id_d;
  logic           last_grant_q, last_grant_d;
  logic           det_clr_n_q, det_clr_n_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_id_q, resp_id_d;
  logic           resp_div3_q, resp_div3_d;
  logic           resp_mismatch_q, resp_mismatch_d;
  logic           grant;
  logic           accept;
  logic           mismatch_now;

  // grant is only meaningful while some valid is high
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = ~req0_valid;
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid && grant;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    state_d         = state_q;
    sreg_d          = sreg_q;
    cnt_d           = cnt_q;
    id_d            = id_q;
    last_grant_d    = last_grant_q;
    resp_valid_d    = 1'b0;
    resp_id_d       = resp_id_q;
    resp_div3_d     = resp_div3_q;
    resp_mismatch_d = resp_mismatch_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d       = grant ? req1_data : req0_data;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = CLR;
        end
      end
      CLR: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sreg_d = {sreg_q[W-2:0], 1'b0};
        if (cnt_q == CW'(W - 1)) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(DET_LAT - 1)) begin
          resp_valid_d    = 1'b1;
          resp_id_d       = id_q;
          resp_div3_d     = det_dout;
          resp_mismatch_d = mismatch_now;
          state_d         = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // registered so the clear is also driven low in the cycle after reset
    det_clr_n_d = (state_d != CLR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      sreg_q          <= '0;
      cnt_q           <= '0;
      id_q            <= 1'b0;
      last_grant_q    <= 1'b1;
      det_clr_n_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= 1'b0;
      resp_div3_q     <= 1'b0;
      resp_mismatch_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      sreg_q          <= sreg_d;
      cnt_q           <= cnt_d;
      id_q            <= id_d;
      last_grant_q    <= last_grant_d;
      det_clr_n_q     <= det_clr_n_d;
      resp_valid_q    <= resp_valid_d;
      resp_id_q       <= resp_id_d;
      resp_div3_q     <= resp_div3_d;
      resp_mismatch_q <= resp_mismatch_d;
    end
  end

`ifdef MOD3_SCHED_SELFCHECK_EN
  logic [1:0] rem_q, rem_d;

  // r' = (2r + bit) mod 3 over the same bit stream the detector sees
  always_comb begin
    rem_d = rem_q;
    if (state_q == CLR) begin
      rem_d = '0;
    end else if (state_q == SHIFT) begin
      case ({rem_q, sreg_q[W-1]})
        3'b000:  rem_d = 2'd0;
        3'b001:  rem_d = 2'd1;
        3'b010:  rem_d = 2'd2;
        3'b011:  rem_d = 2'd0;
        3'b100:  rem_d = 2'd1;
        3'b101:  rem_d = 2'd2;
        default: rem_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rem_q <= '0;
    else        rem_q <= rem_d;
  end

  assign mismatch_now = det_dout != (rem_q == 2'd0);
`else
  assign mismatch_now = 1'b0;
`endif

  assign det_clr_n     = det_clr_n_q;
  assign det_din       = (state_q == SHIFT) & sreg_q[W-1];
  assign busy          = (state_q != IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_div3     = resp_div3_q;
  assign resp_mismatch = resp_mismatch_q;

endmodule

// File: tb/tb_mod3_frame_sched.sv
// Bench for mod3_frame_sched: behavioural serial detector, response monitor and round-robin reference model.
// Honours MOD3_SCHED_SELFCHECK_EN for the expected resp_mismatch behaviour.
module tb_mod3_frame_sched;

  localparam int unsigned W       = 24;
  localparam int unsigned DET_LAT = 1;
  localparam int          LAT     = W + DET_LAT + 1;
`ifdef MOD3_SCHED_SELFCHECK_EN
  localparam bit SELFCHECK = 1'b1;
`else
  localparam bit SELFCHECK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req0_data = '0;
  logic [W-1:0] req1_data = '0;
  logic         req0_ready, req1_ready, det_clr_n, det_din, det_dout;
  logic         resp_valid, resp_id, resp_div3, resp_mismatch, busy;
  logic         det_stuck = 1'b0;

  int det_r = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit model_last = 1'b1;

  typedef struct {bit id; bit div3; bit mm; int t;} resp_t;
  resp_t mon_q[$];

  always #5 clk = ~clk;

  mod3_frame_sched #(.W(W), .DET_LAT(DET_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .det_clr_n(det_clr_n), .det_din(det_din), .det_dout(det_dout),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_div3(resp_div3),
    .resp_mismatch(resp_mismatch), .busy(busy)
  );

  // external detector: one-cycle registered remainder, flag visible after the consuming edge
  always @(posedge clk) begin
    if (!det_clr_n) det_r <= 0;
    else            det_r <= (2 * det_r + int'(det_din)) % 3;
  end
  assign det_dout = det_stuck ? 1'b1 : (det_r == 0);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resp_valid === 1'b1)
      mon_q.push_back('{id: resp_id, div3: resp_div3, mm: resp_mismatch, t: cyc});
  end

  function automatic bit div3_of(input logic [W-1:0] w);
    return (w % 3) == 0;
  endfunction

  task automatic send(input bit id, input logic [W-1:0] data, output int t0, output bit ok);
    ok = 1'b0;
    t0 = -1;
    if (id) begin req1_data = data; req1_valid = 1'b1; end
    else    begin req0_data = data; req0_valid = 1'b1; end
    #1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        @(posedge clk); #1;
        t0 = cyc;
        ok = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    // data changes after acceptance must not affect the frame
    if (id) begin req1_valid = 1'b0; req1_data = ~data; end
    else    begin req0_valid = 1'b0; req0_data = ~data; end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_timeout: req%0d not accepted within 200 cycles", id);
    end
  endtask

  task automatic wait_resp(output resp_t r, output bit ok);
    ok = 1'b0;
    r = '{id: 1'b0, div3: 1'b0, mm: 1'b0, t: 0};
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (mon_q.size() != 0) begin ok = 1'b1; break; end
    end
    #1;
    if (ok) r = mon_q.pop_front();
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL resp_timeout: no resp_valid within 100 cycles, required one");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_chk++;
    if ({det_clr_n, det_din} !== 2'b00) begin
      n_fail++; $display("FAIL reset_det: clr_n,din got %b required 00", {det_clr_n, det_din});
    end
    n_chk++;
    if ({resp_valid, resp_id, resp_div3, resp_mismatch} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_resp: valid,id,div3,mm got %b required 0000",
               {resp_valid, resp_id, resp_div3, resp_mismatch});
    end
    n_chk++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready});
    end
    rst_n = 1'b1;
    model_last = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    int t0;
    bit ok;
    resp_t r;
    w = 24'hA59549;
    send(1'b0, w, t0, ok);
    wait_resp(r, ok);
    n_chk++;
    if ({r.id, r.div3, r.mm} !== {1'b0, div3_of(w), 1'b0}) begin
      n_fail++;
      $display("FAIL single_resp: id,div3,mm got %b%b%b required 0%b0", r.id, r.div3, r.mm, div3_of(w));
    end
    n_chk++;
    if (r.t !== t0 + LAT) begin
      n_fail++; $display("FAIL single_latency: capture edge got %0d required %0d", r.t, t0 + LAT);
    end
    n_chk++;
    if ({resp_valid, resp_id, resp_div3} !== {1'b0, 1'b0, div3_of(w)}) begin
      n_fail++;
      $display("FAIL single_hold: valid,id,div3 got %b required 00%b", {resp_valid, resp_id, resp_div3}, div3_of(w));
    end
    model_last = 1'b0;
  endtask

  task automatic test_serial();
    logic [W-1:0] w, bits;
    int t0;
    bit ok, clr_ok, busy_ok, rdy_bad;
    resp_t r;
    w = 24'hFFFFFF;
    bits = '0;
    clr_ok = 1'b1;
    busy_ok = 1'b1;
    rdy_bad = 1'b0;
    send(1'b1, w, t0, ok);
    n_chk++;
    if ({det_clr_n, det_din} !== 2'b00) begin
      n_fail++; $display("FAIL serial_clr: clr_n,din got %b required 00", {det_clr_n, det_din});
    end
    req0_data = W'($urandom());
    req0_valid = 1'b1;
    for (int k = 0; k < int'(W); k++) begin
      @(posedge clk); #1;
      bits[W-1-k] = det_din;
      clr_ok &= (det_clr_n === 1'b1);
      busy_ok &= (busy === 1'b1);
      rdy_bad |= (req0_ready !== 1'b0);
    end
    req0_valid = 1'b0;
    n_chk++;
    if (bits !== w) begin n_fail++; $display("FAIL serial_bits: got %h required %h", bits, w); end
    n_chk++;
    if ({clr_ok, busy_ok, rdy_bad} !== 3'b110) begin
      n_fail++; $display("FAIL serial_ctrl: clr_ok,busy_ok,ready_seen got %b required 110", {clr_ok, busy_ok, rdy_bad});
    end
    wait_resp(r, ok);
    n_chk++;
    if ({r.id, r.div3, r.mm} !== {1'b1, div3_of(w), 1'b0}) begin
      n_fail++; $display("FAIL serial_resp: id,div3,mm got %b%b%b required 1%b0", r.id, r.div3, r.mm, div3_of(w));
    end
    n_chk++;
    if (r.t !== t0 + LAT) begin
      n_fail++; $display("FAIL serial_latency: got %0d required %0d", r.t, t0 + LAT);
    end
    model_last = 1'b1;
  endtask

  task automatic test_words();
    logic [W-1:0] w;
    bit id, ok;
    int t0;
    resp_t r;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: w = W'(3);
        1: w = '0;
        2: w = W'(4);
        default: begin
          w = W'($urandom());
          if ($urandom_range(0, 1) == 1) w = w - (w % 3);
        end
      endcase
      id = (i < 3) ? 1'b0 : 1'($urandom_range(0, 1));
      send(id, w, t0, ok);
      wait_resp(r, ok);
      n_chk++;
      if ({r.id, r.div3, r.mm} !== {id, div3_of(w), 1'b0}) begin
        n_fail++;
        $display("FAIL words_resp[%0d]: word %h id,div3,mm got %b%b%b required %b%b0",
                 i, w, r.id, r.div3, r.mm, id, div3_of(w));
      end
      n_chk++;
      if (r.t !== t0 + LAT) begin
        n_fail++; $display("FAIL words_latency[%0d]: got %0d required %0d", i, r.t, t0 + LAT);
      end
      model_last = id;
    end
  endtask

  task automatic test_drop_valid();
    req1_data = W'(5);
    req1_valid = 1'b1;
    #1;
    n_chk++;
    if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready_hi: got %b required 1", req1_ready); end
    req1_valid = 1'b0;
    #1;
    n_chk++;
    if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL drop_ready_lo: got %b required 0", req1_ready); end
    repeat (30) @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0 || mon_q.size() != 0) begin
      n_fail++; $display("FAIL drop_no_frame: busy %b responses %0d required 0 and 0", busy, mon_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    int t0, n_before;
    bit ok;
    resp_t r;
    send(1'b0, 24'h123456, t0, ok);
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    n_before = mon_q.size();
    @(posedge clk); #1;
    n_chk++;
    if ({busy, det_clr_n, resp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL midreset_state: busy,clr_n,resp_valid got %b required 000", {busy, det_clr_n, resp_valid});
    end
    rst_n = 1'b1;
    model_last = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    n_chk++;
    if (mon_q.size() != n_before) begin
      n_fail++; $display("FAIL midreset_noresp: responses got %0d required %0d", mon_q.size(), n_before);
    end
    send(1'b0, W'(9), t0, ok);
    wait_resp(r, ok);
    n_chk++;
    if ({r.id, r.div3, r.mm} !== 3'b010 || r.t !== t0 + LAT) begin
      n_fail++;
      $display("FAIL midreset_after: id,div3,mm %b%b%b t %0d required 010 t %0d", r.id, r.div3, r.mm, r.t, t0 + LAT);
    end
    model_last = 1'b0;
  endtask

  task automatic test_selfcheck();
    int t0;
    bit ok;
    resp_t r;
    det_stuck = 1'b1;
    send(1'b0, W'(1), t0, ok);
    wait_resp(r, ok);
    det_stuck = 1'b0;
    n_chk++;
    if ({r.div3, r.mm} !== {1'b1, SELFCHECK}) begin
      n_fail++; $display("FAIL selfcheck_stuck: div3,mm got %b%b required 1%b", r.div3, r.mm, SELFCHECK);
    end
    send(1'b0, W'(1), t0, ok);
    wait_resp(r, ok);
    n_chk++;
    if ({r.div3, r.mm} !== 2'b00) begin
      n_fail++; $display("FAIL selfcheck_good: div3,mm got %b%b required 00", r.div3, r.mm);
    end
    model_last = 1'b0;
  endtask

  task automatic test_fairness();
    logic [W-1:0] d0, d1;
    bit g;
    resp_t r;
    d0 = W'(6);
    d1 = W'(7);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_last = 1'b1;
    mon_q.delete();
    req0_data = d0;
    req1_data = d1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (mon_q.size() >= 8) break;
    end
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_chk++;
    if (mon_q.size() < 8) begin
      n_fail++; $display("FAIL fair_count: responses got %0d required 8", mon_q.size());
    end
    for (int i = 0; i < 8 && mon_q.size() != 0; i++) begin
      g = ~model_last;
      model_last = g;
      r = mon_q.pop_front();
      n_chk++;
      if ({r.id, r.div3, r.mm} !== {g, div3_of(g ? d1 : d0), 1'b0}) begin
        n_fail++;
        $display("FAIL fair_resp[%0d]: id,div3,mm got %b%b%b required %b%b0", i, r.id, r.div3, r.mm, g, div3_of(g ? d1 : d0));
      end
    end
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [W-1:0] d0, d1;
    int mode;
    bit m0, m1, g, a0, a1;
    resp_t exp_q[$];
    resp_t r, e;
    n_chk++;
    if (mon_q.size() != 0) begin
      n_fail++; $display("FAIL rand_stray: leftover responses got %0d required 0", mon_q.size());
    end
    mon_q.delete();
    for (int rnd = 0; rnd < 12; rnd++) begin
      mode = $urandom_range(0, 2);
      m0 = (mode != 1);
      m1 = (mode != 0);
      d0 = W'($urandom());
      d1 = W'($urandom());
      if ($urandom_range(0, 1) == 1) d0 = d0 - (d0 % 3);
      if ($urandom_range(0, 1) == 1) d1 = d1 - (d1 % 3);
      if (m0 && m1) begin
        g = ~model_last;
        exp_q.push_back('{id: g, div3: div3_of(g ? d1 : d0), mm: 1'b0, t: 0});
        exp_q.push_back('{id: ~g, div3: div3_of(g ? d0 : d1), mm: 1'b0, t: 0});
        model_last = ~g;
      end else begin
        g = m1;
        exp_q.push_back('{id: g, div3: div3_of(g ? d1 : d0), mm: 1'b0, t: 0});
        model_last = g;
      end
      req0_data = d0;
      req1_data = d1;
      req0_valid = m0;
      req1_valid = m1;
      #1;
      for (int i = 0; i < 300 && (req0_valid || req1_valid); i++) begin
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        @(posedge clk); #1;
        if (a0) begin req0_valid = 1'b0; req0_data = W'($urandom()); end
        if (a1) begin req1_valid = 1'b0; req1_data = W'($urandom()); end
      end
      n_chk++;
      if (req0_valid || req1_valid) begin
        n_fail++; $display("FAIL rand_accept[%0d]: valids still %b%b required 00", rnd, req0_valid, req1_valid);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    for (int i = 0; i < 200 && (mon_q.size() < exp_q.size() || busy === 1'b1); i++) @(posedge clk);
    #1;
    n_chk++;
    if (mon_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: responses got %0d required %0d", mon_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && mon_q.size() != 0) begin
      e = exp_q.pop_front();
      r = mon_q.pop_front();
      n_chk++;
      if ({r.id, r.div3, r.mm} !== {e.id, e.div3, e.mm}) begin
        n_fail++;
        $display("FAIL rand_resp: id,div3,mm got %b%b%b required %b%b%b", r.id, r.div3, r.mm, e.id, e.div3, e.mm);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_serial();
    test_words();
    test_drop_valid();
    test_reset_midframe();
    test_selfcheck();
    test_fairness();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
